// File: rtl/lab4_ctrl_pkg.sv
// Shared definitions for the lab4 sweep sequencer: state encoding and flag
// index constants for the five-flag combinational block.
package lab4_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_e;

    localparam int NUM_FLAGS   = 5;

    // Bit positions of each flag inside flags_in / hit_cnt
    localparam int FLAG_OUT2   = 0;
    localparam int FLAG_OUT3   = 1;
    localparam int FLAG_OUT4   = 2;
    localparam int FLAG_OUT5   = 3;
    localparam int FLAG_OUTALL = 4;

endpackage

// File: rtl/lab4_hit_counter.sv
// Single saturation-free hit counter. clear wins over a counting enable.
// The width is chosen by the parent so the count can never wrap.
module lab4_hit_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear to zero, otherwise add one when sampling a set flag
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && inc) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/lab4_sweep_ctrl.sv
// Exhaustive sweep sequencer for the five-flag combinational block.
// Drives every input code in turn, holds it SETTLE cycles, samples the flags
// once, and accumulates one hit counter per flag.
// Optional feature macro: LAB4_SWEEP_PAUSE_EN adds a pause input that freezes
// an in-progress sweep.
// Handshake: start and abort are single-cycle pulses sampled on the rising
// edge; abort beats start, start is only honoured in IDLE or DONE.
module lab4_sweep_ctrl
    import lab4_ctrl_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int SETTLE = 1,
    parameter int CNT_W  = WIDTH + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
`ifdef LAB4_SWEEP_PAUSE_EN
    input  logic                       pause,
`endif
    input  logic [NUM_FLAGS-1:0]       flags_in,
    output logic [WIDTH-1:0]           dut_i,
    output logic                       busy,
    output logic                       done,
    output logic [NUM_FLAGS*CNT_W-1:0] hit_cnt,
    output logic [1:0]                 dbg_state
);

    localparam int               SET_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);
    localparam logic [WIDTH-1:0] MAX_CODE = '1;

    sweep_state_e     state_q, state_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [WIDTH-1:0] dut_q, dut_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cnt_clear;
    logic             cnt_en;
    logic             frozen;

`ifdef LAB4_SWEEP_PAUSE_EN
    // Pause only has meaning while a sweep is running
    assign frozen = pause && (state_q == ST_DRIVE || state_q == ST_SAMPLE);
`else
    assign frozen = 1'b0;
`endif

    // Next-state and registered-output logic; abort overrides everything
    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        dut_d     = dut_q;
        busy_d    = busy_q;
        done_d    = done_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        if (abort) begin
            state_d  = ST_IDLE;
            settle_d = '0;
            dut_d    = '0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
        end else if (!frozen) begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d   = ST_DRIVE;
                        settle_d  = '0;
                        dut_d     = '0;
                        busy_d    = 1'b1;
                        done_d    = 1'b0;
                        cnt_clear = 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (settle_q == SET_LAST) begin
                        state_d  = ST_SAMPLE;
                        settle_d = '0;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    cnt_en = 1'b1;
                    if (dut_q == MAX_CODE) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_DRIVE;
                        dut_d   = dut_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            dut_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            dut_q    <= dut_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // One hit counter per flag, packed flag k at [k*CNT_W +: CNT_W]
    for (genvar k = 0; k < NUM_FLAGS; k++) begin : g_cnt
        lab4_hit_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk    (clk),
            .rst_n  (rst_n),
            .clear  (cnt_clear),
            .enable (cnt_en),
            .inc    (flags_in[k]),
            .count  (hit_cnt[k*CNT_W +: CNT_W])
        );
    end

    assign dut_i     = dut_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_lab4_sweep_ctrl.sv
// Bench for lab4_sweep_ctrl. The flag block is modelled as a lookup table
// indexed by the driven code; expected counts are sums over the sampled codes.
module tb_lab4_sweep_ctrl;

    localparam int WIDTH  = 5;
    localparam int SETTLE = 1;
    localparam int CNT_W  = WIDTH + 1;
    localparam int NCODES = 1 << WIDTH;
    localparam int LAT    = (SETTLE + 1) * NCODES + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             pause = 1'b0;
    logic [4:0]       flags_in;
    logic [WIDTH-1:0] dut_i;
    logic             busy;
    logic             done;
    logic [5*CNT_W-1:0] hit_cnt;
    logic [1:0]       dbg_state;

    logic [4:0] flag_tab [NCODES];
    int checks = 0;
    int errors = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    assign flags_in = flag_tab[dut_i];

    lab4_sweep_ctrl #(.WIDTH(WIDTH), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
`ifdef LAB4_SWEEP_PAUSE_EN
        .pause     (pause),
`endif
        .flags_in  (flags_in),
        .dut_i     (dut_i),
        .busy      (busy),
        .done      (done),
        .hit_cnt   (hit_cnt),
        .dbg_state (dbg_state)
    );

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Flag block per the divisibility rule: flag k set when code % (k+2) == 0,
    // outall is the AND of the four divisibility flags.
    task automatic fill_model();
        for (int c = 0; c < NCODES; c++) begin
            logic [4:0] f;
            for (int k = 0; k < 4; k++) f[k] = ((c % (k + 2)) == 0);
            f[4] = &f[3:0];
            flag_tab[c] = f;
        end
    endtask

    task automatic fill_const(input logic [4:0] v);
        for (int c = 0; c < NCODES; c++) flag_tab[c] = v;
    endtask

    task automatic fill_random();
        for (int c = 0; c < NCODES; c++) flag_tab[c] = 5'($urandom_range(0, 31));
    endtask

    // Expected counters after codes 0..ncodes-1 have been sampled
    task automatic check_counts(input string tag, input int ncodes);
        for (int k = 0; k < 5; k++) begin
            int e = 0;
            for (int c = 0; c < ncodes; c++) e += int'(flag_tab[c][k]);
            check($sformatf("%s_cnt%0d", tag, k), 32'(hit_cnt[k*CNT_W +: CNT_W]), 32'(e));
        end
    endtask

    // Pulse start, run to done, optionally pause and/or poke start mid-sweep.
    task automatic run_sweep(input string tag, input int exp_cycles,
                             input int pause_at, input int pause_len, input int poke_at);
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        check({tag, "_busy1"}, 32'(busy), 32'd1);
        check({tag, "_dut0"},  32'(dut_i), 32'd0);
        check({tag, "_done0"}, 32'(done), 32'd0);
        while (!done && n < exp_cycles + 50) begin
            start = (n == poke_at);
            pause = (n >= pause_at && n < pause_at + pause_len);
            tick();
            n++;
        end
        start = 1'b0;
        pause = 1'b0;
        check({tag, "_latency"}, 32'(n), 32'(exp_cycles));
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        check({tag, "_state_done"}, 32'(dbg_state), 32'd3);
    endtask

    // Start a sweep and abort it on the first cycle the code equals target
    task automatic abort_at(input string tag, input int target);
        int n = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (int'(dut_i) != target && n < LAT + 10) begin
            tick();
            n++;
        end
        check({tag, "_reached"}, 32'(dut_i), 32'(target));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check({tag, "_state"}, 32'(dbg_state), 32'd0);
        check({tag, "_dut"},   32'(dut_i), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check_counts(tag, target);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int tgt;
        int poke;
        fill_model();
        repeat (3) tick();
        check("rst_dut",   32'(dut_i), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_hit",   32'(hit_cnt != '0), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1. Full sweep against the divisibility flag block
        run_sweep("model", LAT, -1, 0, -1);
        check("model_out2", 32'(hit_cnt[0*CNT_W +: CNT_W]), 32'd16);
        check("model_out3", 32'(hit_cnt[1*CNT_W +: CNT_W]), 32'd11);
        check("model_out4", 32'(hit_cnt[2*CNT_W +: CNT_W]), 32'd8);
        check("model_out5", 32'(hit_cnt[3*CNT_W +: CNT_W]), 32'd7);
        check("model_all",  32'(hit_cnt[4*CNT_W +: CNT_W]), 32'd1);
        check("model_dut_held", 32'(dut_i), 32'(NCODES - 1));
        repeat (3) tick();
        check_counts("model_hold", NCODES);

        // 2. Constant flag patterns: boundary counts
        fill_const(5'b11111);
        run_sweep("ones", LAT, -1, 0, -1);
        check_counts("ones", NCODES);
        check("ones_max", 32'(hit_cnt[4*CNT_W +: CNT_W]), 32'(NCODES));
        fill_const(5'b00000);
        run_sweep("zeros", LAT, -1, 0, -1);
        check_counts("zeros", NCODES);

        // 3. Abort at code 10, then at a random code
        fill_model();
        abort_at("abort10", 10);
        check("abort10_out2", 32'(hit_cnt[0*CNT_W +: CNT_W]), 32'd5);
        repeat (4) tick();
        check_counts("abort10_frozen", 10);
        fill_random();
        tgt = $urandom_range(1, NCODES - 1);
        abort_at("abort_rnd", tgt);

        // 4. start+abort together in IDLE stays IDLE with counts untouched
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("sa_state", 32'(dbg_state), 32'd0);
        check("sa_busy",  32'(busy), 32'd0);
        check_counts("sa_frozen", tgt);

        // 4. start mid-sweep ignored; random table
        poke = $urandom_range(3, LAT - 5);
        run_sweep("poke", LAT, -1, 0, poke);
        check_counts("poke", NCODES);

        // 5. start while DONE repeats with identical counts
        run_sweep("again", LAT, -1, 0, -1);
        check_counts("again", NCODES);

`ifdef LAB4_SWEEP_PAUSE_EN
        // 6. Pause 10 cycles mid-sweep
        fill_model();
        run_sweep("pause", LAT + 10, 20, 10, -1);
        check_counts("pause", NCODES);
`endif

        // 6. Async reset mid-sweep clears outputs immediately
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (15) tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_dut",   32'(dut_i), 32'd0);
        check("arst_busy",  32'(busy), 32'd0);
        check("arst_done",  32'(done), 32'd0);
        check("arst_hit",   32'(hit_cnt != '0), 32'd0);
        check("arst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
